rom_frame_streamer: RTL and testbench

//   Sequences the 2048x32 template ROM (11-bit address, 32-bit q, one clock) to stream
//   a word range out as a frame on a valid/ready stream: sop, eop, backpressure.

---
 rtl/rom_stream_pkg.sv | 21 ++
 rtl/rom_stream_fifo.sv | 64 ++++++
 rtl/rom_frame_streamer.sv | 185 ++++++++++++++++++
 tb/tb_rom_frame_streamer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// Shared types and helpers for the ROM frame streamer: FSM state encoding,
// default ROM latency and the ones' complement accumulate step.
package rom_stream_pkg;

   localparam int unsigned ROM_LATENCY_DEF = 2;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDrain,
      StDone
   } state_e;

   // 16-bit add with end-around carry; a single fold cannot carry out again.
   function automatic logic [15:0] csum_fold_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[15:0] + {15'd0, sum[16]};
   endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Synchronous FIFO carrying stream beats (data plus sop/eop) with occupancy output.
// First-word fall-through: rdata_o shows the head entry whenever empty_o is low.
module rom_stream_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 34
) (
   input  logic                       clk_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push  = push_i && (count_q != CNT_W'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/rom_frame_streamer.sv
// Streams a word range of the template ROM as a sop/eop framed valid/ready stream.
// Optional checksum generation is enabled by defining ROM_STREAM_CSUM_EN.
module rom_frame_streamer
   import rom_stream_pkg::*;
#(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned LEN_W       = 12,
   parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEF,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [15:0]       csum
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_depth_check
      $error("FIFO_DEPTH must be at least ROM_LATENCY+1");
   end
   if (ROM_LATENCY < 1) begin : g_latency_check
      $error("ROM_LATENCY must be at least 1");
   end

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      rom_address_q, rom_address_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic                   first_q, first_d;
   logic [ROM_LATENCY-1:0] inflight_q, inflight_d;
   logic [ROM_LATENCY-1:0] sop_pipe_q, sop_pipe_d;
   logic [ROM_LATENCY-1:0] eop_pipe_q, eop_pipe_d;

   logic                   issue;
   logic                   beat_xfer;
   logic [31:0]            occupancy;
   logic                   fifo_push;
   logic [DATA_W+1:0]      fifo_wdata;
   logic [DATA_W+1:0]      fifo_rdata;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;

   // Reads still travelling through the ROM count against FIFO space.
   assign occupancy = 32'(fifo_count) + 32'($countones(inflight_q));
   assign beat_xfer = out_valid && out_ready;

   always_comb begin
      state_d       = state_q;
      rom_address_d = rom_address_q;
      rem_d         = rem_q;
      first_d       = first_q;
      issue         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               rom_address_d = base_addr;
               rem_d         = len;
               first_d       = 1'b1;
               state_d       = (len == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            if (occupancy < 32'(FIFO_DEPTH)) begin
               issue         = 1'b1;
               rom_address_d = rom_address_q + ADDR_W'(1);
               rem_d         = rem_q - LEN_W'(1);
               first_d       = 1'b0;
               if (rem_q == LEN_W'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (beat_xfer && out_eop) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Beat markers ride alongside each read so the FIFO entry is self-describing.
   always_comb begin
      inflight_d = (inflight_q << 1) | ROM_LATENCY'(issue);
      sop_pipe_d = (sop_pipe_q << 1) | ROM_LATENCY'(issue && first_q);
      eop_pipe_d = (eop_pipe_q << 1) | ROM_LATENCY'(issue && (rem_q == LEN_W'(1)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         rom_address_q <= '0;
         rem_q         <= '0;
         first_q       <= 1'b0;
         inflight_q    <= '0;
         sop_pipe_q    <= '0;
         eop_pipe_q    <= '0;
      end else begin
         state_q       <= state_d;
         rom_address_q <= rom_address_d;
         rem_q         <= rem_d;
         first_q       <= first_d;
         inflight_q    <= inflight_d;
         sop_pipe_q    <= sop_pipe_d;
         eop_pipe_q    <= eop_pipe_d;
      end
   end

   assign fifo_push  = inflight_q[ROM_LATENCY-1];
   assign fifo_wdata = {sop_pipe_q[ROM_LATENCY-1], eop_pipe_q[ROM_LATENCY-1], rom_q};

   rom_stream_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(DATA_W + 2)
   ) u_fifo (
      .clk_i  (clock),
      .flush_i(reset),
      .push_i (fifo_push),
      .wdata_i(fifo_wdata),
      .pop_i  (out_ready),
      .rdata_o(fifo_rdata),
      .empty_o(fifo_empty),
      .count_o(fifo_count)
   );

   assign out_valid   = !fifo_empty;
   assign out_data    = fifo_rdata[DATA_W-1:0];
   assign out_sop     = out_valid && fifo_rdata[DATA_W+1];
   assign out_eop     = out_valid && fifo_rdata[DATA_W];
   assign rom_address = rom_address_q;
   assign busy        = (state_q == StFetch) || (state_q == StDrain);
   assign done        = (state_q == StDone);

`ifdef ROM_STREAM_CSUM_EN
   logic [15:0] acc_q, acc_d;
   logic [15:0] csum_q, csum_d;

   always_comb begin
      acc_d  = acc_q;
      csum_d = csum_q;
      if ((state_q == StIdle) && start) begin
         acc_d  = '0;
         csum_d = '0;
      end else if (beat_xfer) begin
         acc_d = csum_fold_add(csum_fold_add(acc_q, out_data[DATA_W-1 -: 16]), out_data[15:0]);
      end
      // Latch the final result as the FSM enters DONE, including the eop beat.
      if ((state_d == StDone) && (state_q != StDone)) begin
         csum_d = ~acc_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q  <= '0;
         csum_q <= '0;
      end else begin
         acc_q  <= acc_d;
         csum_q <= csum_d;
      end
   end

   assign csum = csum_q;
`else
   assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Directed bench for rom_frame_streamer with a ROM model and beat scoreboard.
module tb_rom_frame_streamer;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [11:0] len;
   logic        busy;
   logic        done;
   logic [10:0] rom_address;
   logic [31:0] rom_q;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;
   logic [15:0] csum;

   logic [31:0] rom_mem [2048];
   logic [31:0] rom_pipe [2];
   beat_t       exp_q [$];
   logic [15:0] exp_csum;
   int          tests = 0;
   int          fails = 0;
   int          beats_seen = 0;
   int          max_fifo = 0;
   int          ready_mode = 0;

   always #5 clock = ~clock;

   // Two-cycle registered ROM
   always @(posedge clock) begin
      rom_pipe[0] <= rom_mem[rom_address];
      rom_pipe[1] <= rom_pipe[0];
   end
   assign rom_q = rom_pipe[1];

   rom_frame_streamer u_dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .rom_address(rom_address),
      .rom_q      (rom_q),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .csum       (csum)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Queue expected beats and checksum, then present start for one cycle.
   task automatic start_frame(input logic [10:0] b, input logic [11:0] l);
      logic [31:0] s;
      logic [31:0] w;
      logic [10:0] a;
      s = 32'd0;
      for (int k = 0; k < int'(l); k++) begin
         a = b + 11'(k);
         w = rom_mem[a];
         exp_q.push_back('{data: w, sop: (k == 0), eop: (k == int'(l) - 1)});
         s = s + {16'h0, w[31:16]} + {16'h0, w[15:0]};
      end
      while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
`ifdef ROM_STREAM_CSUM_EN
      exp_csum = ~s[15:0];
`else
      exp_csum = 16'h0000;
`endif
      start     = 1'b1;
      base_addr = b;
      len       = l;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         next_cycle();
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            check({tag, "_csum"}, 64'(csum), 64'(exp_csum));
            check({tag, "_busy_low"}, 64'(busy), 64'd0);
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle();
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every transfer and checks stall stability.
   initial begin
      bit    stall_held;
      beat_t held;
      beat_t e;
      stall_held = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall_held = 1'b0;
         end else begin
            if (int'(u_dut.fifo_count) > max_fifo) max_fifo = int'(u_dut.fifo_count);
            if (stall_held) begin
               check("stall_valid", 64'(out_valid), 64'd1);
               check("stall_beat", 64'({out_data, out_sop, out_eop}), 64'(held));
            end
            if (out_valid && out_ready) begin
               beats_seen++;
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 64'(out_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 64'({out_data, out_sop, out_eop}), 64'(e));
               end
            end
            stall_held = out_valid && !out_ready;
            held       = '{data: out_data, sop: out_sop, eop: out_eop};
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] ea;
      int          b0;
      bit          saw_valid;
      bit          reached;

      for (int i = 0; i < 2048; i++) rom_mem[i] = {16'(i) ^ 16'hA5A5, 16'(i)};
      rom_mem[11'h100] = 32'h0001_0002;
      rom_mem[11'h101] = 32'hFFFF_0000;

      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      idle(2);
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
      check("rst_addr", 64'(rom_address), 64'd0);
      check("rst_csum", 64'(csum), 64'd0);
      next_cycle();
      reset = 1'b0;
      idle(2);

      // 1: cycle-exact timing with ready held high
      start_frame(11'h010, 12'd4);
      for (int c = 1; c <= 9; c++) begin
         next_cycle();
         @(negedge clock);
         if (c <= 4) check("t1_addr", 64'(rom_address), 64'(11'h010 + 11'(c - 1)));
         check("t1_valid", 64'(out_valid), 64'(c >= 4 && c <= 7));
         check("t1_sop", 64'(out_sop), 64'(c == 4));
         check("t1_eop", 64'(out_eop), 64'(c == 7));
         check("t1_done", 64'(done), 64'(c == 8));
         check("t1_busy", 64'(busy), 64'(c >= 1 && c <= 7));
         if (c == 8) check("t1_csum", 64'(csum), 64'(exp_csum));
      end
      check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

      // 2: alternating backpressure
      ready_mode = 1;
      idle(2);
      max_fifo = 0;
      start_frame(11'h040, 12'd8);
      wait_done("t2");
      check("t2_fifo_max_le4", 64'(max_fifo <= 4), 64'd1);
      ready_mode = 0;
      idle(2);

      // 3: address wrap
      start_frame(11'h7FE, 12'd3);
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         @(negedge clock);
         ea = 11'h7FE + 11'(c - 1);
         check("t3_addr", 64'(rom_address), 64'(ea));
      end
      wait_done("t3");

      // 4: zero length, then single beat
      idle(1);
      start_frame(11'h123, 12'd0);
      next_cycle();
      @(negedge clock);
      check("t4_zero_done", 64'(done), 64'd1);
      check("t4_zero_busy", 64'(busy), 64'd0);
      check("t4_zero_valid", 64'(out_valid), 64'd0);
      check("t4_zero_csum", 64'(csum), 64'(exp_csum));
      next_cycle();
      @(negedge clock);
      check("t4_zero_done_pulse", 64'(done), 64'd0);
      idle(1);
      start_frame(11'h055, 12'd1);
      wait_done("t4_one");

      // 5: reset during beat 2 of 6
      idle(1);
      b0 = beats_seen;
      start_frame(11'h300, 12'd6);
      reached = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
         next_cycle();
         @(negedge clock);
         if (beats_seen - b0 >= 2) reached = 1'b1;
      end
      check("t5_reached_beat2", 64'(reached), 64'd1);
      next_cycle();
      reset = 1'b1;
      exp_q.delete();
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_done", 64'(done), 64'd0);
      check("t5_rst_valid", 64'(out_valid), 64'd0);
      check("t5_rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
      check("t5_rst_addr", 64'(rom_address), 64'd0);
      check("t5_rst_csum", 64'(csum), 64'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         @(negedge clock);
         if (out_valid) saw_valid = 1'b1;
      end
      check("t5_no_stale", 64'(saw_valid), 64'd0);
      start_frame(11'h300, 12'd6);
      wait_done("t5_fresh");

      // 6: checksum vector, start while busy ignored
      idle(1);
      start_frame(11'h100, 12'd2);
`ifdef ROM_STREAM_CSUM_EN
      check("t6_model_vector", 64'(exp_csum), 64'h0000_FFFC);
`endif
      next_cycle();
      start     = 1'b1;
      base_addr = 11'h200;
      len       = 12'd5;
      wait_done("t6");
      next_cycle();
      @(negedge clock);
      check("t6_csum_held", 64'(csum), 64'(exp_csum));
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         @(negedge clock);
         if (out_valid || busy) saw_valid = 1'b1;
      end
      check("t6_spurious_ignored", 64'(saw_valid), 64'd0);

      // 7: longer frame under random backpressure
      ready_mode = 2;
      idle(2);
      max_fifo = 0;
      start_frame(11'h5F0, 12'd20);
      wait_done("t7");
      check("t7_fifo_max_le4", 64'(max_fifo <= 4), 64'd1);
      ready_mode = 0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
